// File: rtl/disp_scan_pkg.sv
// Shared constants and types for the multiplexed 4-digit display scanner.
package disp_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode select for a digit slot.
  function automatic logic [NUM_DIGITS-1:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/disp_scan_tick.sv
// Digit-slot prescaler: cnt runs 0..CLK_DIV-1, tick marks the last cycle of a slot.
module disp_scan_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] cnt_o,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == 16'(CLK_DIV - 1));
  assign cnt_d  = tick_o ? '0 : cnt_q + 16'd1;
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with frame-synchronous update handshake.
// Optional macro DISP_ZERO_SUPPRESS_EN enables leading-zero suppression of digits 3..1.
module disp_scan_ctrl
  import disp_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic [3:0]  point_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  hex_out,
  output logic        point_out,
  output logic        le_out,
  output logic [3:0]  an,
  output logic        frame_done
);

  logic [15:0] cnt;
  logic        tick;
  logic        wrap;

  digit_idx_t  idx_q, idx_d;
  logic [15:0] pend_data_q, pend_data_d, shad_data_q, shad_data_d;
  logic [3:0]  pend_point_q, pend_point_d, shad_point_q, shad_point_d;
  logic [3:0]  pend_blank_q, pend_blank_d, shad_blank_q, shad_blank_d;
  logic        busy_q, busy_d;
  logic [3:0]  an_q, an_d, hex_q, hex_d;
  logic        pt_q, pt_d, le_q, le_d, fd_q, fd_d;
  logic [3:0]  blank_eff;

  disp_scan_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_o (cnt),
    .tick_o(tick)
  );

  assign wrap = tick && (idx_q == 2'd3);

`ifdef DISP_ZERO_SUPPRESS_EN
  logic [3:0] suppress;
  logic       zero_run;

  // A digit is suppressed only while it and every digit above it are zero with no point.
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run & (shad_data_q[4*i +: 4] == 4'h0) & ~shad_point_q[i];
      suppress[i] = zero_run;
    end
    blank_eff = shad_blank_q | suppress;
  end
`else
  assign blank_eff = shad_blank_q;
`endif

  always_comb begin
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    pend_data_d  = pend_data_q;
    pend_point_d = pend_point_q;
    pend_blank_d = pend_blank_q;
    shad_data_d  = shad_data_q;
    shad_point_d = shad_point_q;
    shad_blank_d = shad_blank_q;
    busy_d       = busy_q;

    // Transfer decision uses the pre-edge busy, so a load landing on the wrap
    // edge with busy=0 is captured and held for the next frame.
    if (wrap && busy_q) begin
      shad_data_d  = pend_data_q;
      shad_point_d = pend_point_q;
      shad_blank_d = pend_blank_q;
      busy_d       = 1'b0;
    end
    if (load && !busy_q) begin
      pend_data_d  = data_in;
      pend_point_d = point_in;
      pend_blank_d = blank_in;
      busy_d       = 1'b1;
    end

    an_d  = (cnt == 16'd0) ? AN_OFF : an_select(idx_q);
    hex_d = shad_data_q[{idx_q, 2'b00} +: 4];
    pt_d  = shad_point_q[idx_q];
    le_d  = (cnt == 16'd0) | blank_eff[idx_q];
    fd_d  = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_point_q <= '0;
      pend_blank_q <= '0;
      shad_data_q  <= '0;
      shad_point_q <= '0;
      shad_blank_q <= '0;
      busy_q       <= 1'b0;
      an_q         <= AN_OFF;
      hex_q        <= '0;
      pt_q         <= 1'b0;
      le_q         <= 1'b1;
      fd_q         <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_point_q <= pend_point_d;
      pend_blank_q <= pend_blank_d;
      shad_data_q  <= shad_data_d;
      shad_point_q <= shad_point_d;
      shad_blank_q <= shad_blank_d;
      busy_q       <= busy_d;
      an_q         <= an_d;
      hex_q        <= hex_d;
      pt_q         <= pt_d;
      le_q         <= le_d;
      fd_q         <= fd_d;
    end
  end

  assign busy       = busy_q;
  assign an         = an_q;
  assign hex_out    = hex_q;
  assign point_out  = pt_q;
  assign le_out     = le_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a frame-position model predicts every output cycle.
module tb_disp_scan_ctrl;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        busy, point_out, le_out, frame_done;
  logic [3:0]  hex_out, an;

  disp_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .point_in  (point_in),
    .blank_in  (blank_in),
    .load      (load),
    .busy      (busy),
    .hex_out   (hex_out),
    .point_out (point_out),
    .le_out    (le_out),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] hex;
    logic       pt;
    logic       le;
    logic       busy;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   started = 0;
  bit   done = 0;

  // Model: position within the frame plus displayed / queued display contents.
  int          p = 0;
  logic [15:0] sh_d = '0, pe_d = '0;
  logic [3:0]  sh_p = '0, sh_b = '0, pe_p = '0, pe_b = '0;
  bit          m_busy = 0;
  logic        prev_rn = 1'b1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit blank_of(input int k);
    if (sh_b[k]) return 1'b1;
`ifdef DISP_ZERO_SUPPRESS_EN
    if (k > 0) begin
      bit all_zero = 1'b1;
      for (int j = k; j < 4; j++)
        if (sh_d[4*j +: 4] != 4'h0 || sh_p[j]) all_zero = 1'b0;
      if (all_zero) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] pt,
                      input logic [3:0] bl, input logic rn);
    exp_t e;
    int   digit, c;
    bit   old_busy;
    @(negedge clk);
    load = ld; data_in = d; point_in = pt; blank_in = bl; rst_n = rn;
    if (!rn) begin
      e = '{an: 4'hF, hex: 4'h0, pt: 1'b0, le: 1'b1, busy: 1'b0, fd: 1'b0};
      p = 0; sh_d = '0; sh_p = '0; sh_b = '0; pe_d = '0; pe_p = '0; pe_b = '0; m_busy = 0;
    end else begin
      digit = p / D;
      c     = p % D;
      e.an  = (c == 0) ? 4'hF : ~(4'b0001 << digit);
      e.hex = sh_d[4*digit +: 4];
      e.pt  = sh_p[digit];
      e.le  = (c == 0) || blank_of(digit);
      e.fd  = (p == FRAME - 1);
      old_busy = m_busy;
      if (p == FRAME - 1 && old_busy) begin
        sh_d = pe_d; sh_p = pe_p; sh_b = pe_b; m_busy = 0;
      end
      if (ld && !old_busy) begin
        pe_d = d; pe_p = pt; pe_b = bl; m_busy = 1;
      end
      e.busy = m_busy;
      p = (p + 1) % FRAME;
    end
    q.push_back(e);
    started = 1;
    if (!rn && prev_rn) begin
      #1;
      chk("async_rst_busy", 16'(busy), 16'(1'b0));
      chk("async_rst_an", 16'(an), 16'h000F);
      chk("async_rst_le", 16'(le_out), 16'(1'b1));
    end
    prev_rn = rn;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && p != target; i++) step(1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
    chk("run_to_reached", 16'(p), 16'(target));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", 16'(an), 16'(e.an));
        chk("hex_out", 16'(hex_out), 16'(e.hex));
        chk("point_out", 16'(point_out), 16'(e.pt));
        chk("le_out", 16'(le_out), 16'(e.le));
        chk("busy", 16'(busy), 16'(e.busy));
        chk("frame_done", 16'(frame_done), 16'(e.fd));
      end else if (started && !done) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
      end
    end
  end

  initial begin : driver
    logic [15:0] rd, mask;
    // Reset, then release and watch the anode scan.
    step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    idle(FRAME + 3);
    // Load 1A3F in this frame, second load ignored while busy.
    run_to(2);
    step(1'b1, 16'h1A3F, 4'h0, 4'h0, 1'b1);
    idle(3);
    step(1'b1, 16'h5555, 4'hF, 4'hF, 1'b1);
    idle(2 * FRAME);
    // Blank digit 2, point on digit 0.
    step(1'b1, 16'h1234, 4'b0001, 4'b0100, 1'b1);
    idle(2 * FRAME);
    // Leading zeros.
    step(1'b1, 16'h0070, 4'h0, 4'h0, 1'b1);
    idle(2 * FRAME);
    step(1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
    idle(2 * FRAME);
    step(1'b1, 16'h00A0, 4'b0100, 4'h0, 1'b1);
    idle(2 * FRAME);
    // Load landing exactly on the wrap edge with busy clear.
    run_to(FRAME - 1);
    step(1'b1, 16'hBEEF, 4'b1010, 4'b0001, 1'b1);
    idle(2 * FRAME);
    // Mid-frame reset while an update is pending in the digit-2 slot.
    run_to(0);
    step(1'b1, 16'hC0DE, 4'hF, 4'h0, 1'b1);
    run_to(2 * D + 1);
    step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    idle(2 * FRAME);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       mask = 16'h000F;
        1:       mask = 16'h00FF;
        2:       mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      rd = 16'($urandom) & mask;
      step($urandom_range(0, 7) == 0, rd,
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
           $urandom_range(0, 199) != 0);
    end
    idle(2);
    @(posedge clk);
    #2;
    done = 1;
    chk("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
